// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC, ROM addressing, prefetch FIFO, redirect flush.
// Optional perf counters are enabled with `define IFU_PERF_CNT_EN.
module inst_fetch_unit #(
  parameter int          ADDR_WIDTH = 7,
  parameter logic [31:0] RESET_PC   = 32'h00000000,
  parameter int          DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [31:0]           rom_data,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_inst,
  output logic [31:0]           out_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall,
  output logic [31:0]           perf_redirect
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   r_pc;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [31:0]   r_mem_pc   [DEPTH];
  logic [31:0]   r_mem_inst [DEPTH];

  logic w_pop;
  logic w_push;
  logic w_not_full;

  assign rom_addr   = r_pc[ADDR_WIDTH+1:2];
  assign out_valid  = (r_count != '0);
  assign w_not_full = (r_count < CW'(DEPTH));
  assign w_pop      = out_valid & out_ready;
  assign w_push     = ~redirect_valid & (w_not_full | w_pop);

  // Empty FIFO drives zeros so decode never sees stale or X data.
  assign out_inst = out_valid ? r_mem_inst[r_head] : 32'h0;
  assign out_pc   = out_valid ? r_mem_pc[r_head]   : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (redirect_valid) begin
      r_pc    <= {redirect_pc[31:2], 2'b00};
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_pc   <= r_pc + 32'd4;
        r_tail <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_tail]   <= r_pc;
      r_mem_inst[r_tail] <= rom_data;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_stall    <= '0;
      r_perf_redirect <= '0;
    end else begin
      if (out_valid && !out_ready && r_perf_stall != 32'hFFFFFFFF) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      if (redirect_valid && r_perf_redirect != 32'hFFFFFFFF) begin
        r_perf_redirect <= r_perf_redirect + 32'd1;
      end
    end
  end

  assign perf_stall    = r_perf_stall;
  assign perf_redirect = r_perf_redirect;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a combinational ROM model.
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst;
  logic [6:0]  rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  int n_checks;
  int n_fail;

  inst_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc)
  );

  assign rom_data = 32'hA000_0000 + {25'd0, rom_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    step();
    rst = 1'b0;
  endtask

  task automatic redir(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #2;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_inst", out_inst, 32'd0);
    check("rst_addr", {25'd0, rom_addr}, 32'd0);

    // 1: streaming after reset
    do_reset();
    check("s1_bubble", {31'd0, out_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("s1_valid", {31'd0, out_valid}, 32'd1);
      check("s1_pc", out_pc, 32'(k * 4));
      check("s1_inst", out_inst, 32'hA000_0000 + 32'(k));
    end

    // 2: stall fills FIFO then drains in order
    out_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 5; k++) step();
    check("s2_addr_hold", {25'd0, rom_addr}, 32'd2);
    check("s2_pc_hold", out_pc, 32'd0);
    out_ready = 1'b1;
    step();
    check("s2_pc4", out_pc, 32'd4);
    check("s2_addr_adv", {25'd0, rom_addr}, 32'd3);
    step();
    check("s2_pc8", out_pc, 32'd8);
    check("s2_inst8", out_inst, 32'hA000_0002);

    // 3: redirect while full, misaligned target
    out_ready = 1'b0;
    do_reset();
    step();
    step();
    redir(32'h0000_0043);
    check("s3_bubble", {31'd0, out_valid}, 32'd0);
    check("s3_addr", {25'd0, rom_addr}, 32'd16);
    step();
    check("s3_valid", {31'd0, out_valid}, 32'd1);
    check("s3_pc", out_pc, 32'h40);
    check("s3_inst", out_inst, 32'hA000_0010);

    // 4: redirect coinciding with pop of pc 8
    out_ready = 1'b1;
    do_reset();
    step();
    step();
    step();
    check("s4_head8", out_pc, 32'd8);
    redir(32'h0000_0100);
    check("s4_bubble", {31'd0, out_valid}, 32'd0);
    step();
    check("s4_tgt_pc", out_pc, 32'h100);
    check("s4_tgt_inst", out_inst, 32'hA000_0040);

    // 5: ROM address wrap
    redir(32'h0000_01FC);
    check("s5_addr127", {25'd0, rom_addr}, 32'd127);
    step();
    check("s5_pc1fc", out_pc, 32'h1FC);
    check("s5_inst7f", out_inst, 32'hA000_007F);
    check("s5_addr0", {25'd0, rom_addr}, 32'd0);
    step();
    check("s5_pc200", out_pc, 32'h200);
    check("s5_inst0", out_inst, 32'hA000_0000);

    // 32-bit pc wrap
    redir(32'hFFFF_FFFC);
    step();
    check("pcwrap_top", out_pc, 32'hFFFF_FFFC);
    step();
    check("pcwrap_zero", out_pc, 32'h0);

    // 6: asynchronous reset mid-stream
    step();
    check("s6_pre", {31'd0, out_valid}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("s6_async_valid", {31'd0, out_valid}, 32'd0);
    check("s6_async_pc", out_pc, 32'd0);
    check("s6_async_addr", {25'd0, rom_addr}, 32'd0);
    step();
    rst = 1'b0;
    step();
    check("s6_restart_pc", out_pc, 32'd0);
    check("s6_restart_v", {31'd0, out_valid}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
